// File: rtl/hash_bridge_pkg.sv
// rtl/hash_bridge_pkg.sv - register map, bit indices, capture states and byte-reverse helpers
package hash_bridge_pkg;

  localparam logic [5:0] ADDR_DATA_LO  = 6'h00;
  localparam logic [5:0] ADDR_DATA_HI  = 6'h01;
  localparam logic [5:0] ADDR_CTRL     = 6'h02;
  localparam logic [5:0] ADDR_STATUS   = 6'h03;
  localparam logic [5:0] ADDR_SOFT_RST = 6'h0F;

  localparam int CTRL_SWAP_IN  = 0;
  localparam int CTRL_SWAP_OUT = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int ST_HASH_READY = 0;
  localparam int ST_FIFO_FULL  = 1;
  localparam int ST_FIFO_EMPTY = 2;
  localparam int ST_OVERFLOW   = 3;
  localparam int ST_BUSY       = 4;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_COLLECT = 2'd1,
    CAP_DONE    = 2'd2
  } cap_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] v);
    return {bswap32(v[31:0]), bswap32(v[63:32])};
  endfunction

  // Lane mask follows the bytes when the data word is reversed.
  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/hash_word_fifo.sv
// rtl/hash_word_fifo.sv - synchronous word FIFO with level output and same-cycle push/pop
module hash_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hash_avalon_bridge.sv
// rtl/hash_avalon_bridge.sv - Avalon-MM slave feeding a hash core input FIFO and capturing its digest
module hash_avalon_bridge
  import hash_bridge_pkg::*;
#(
  parameter int HASH_SIZE  = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        core_rst,
  output logic        core_src_ready,
  input  logic        core_src_read,
  output logic [63:0] core_din,
  output logic        core_dst_ready,
  input  logic        core_dst_write,
  input  logic [63:0] core_dout
);

  localparam int BEATS = HASH_SIZE / 64;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  logic             acc_wr, acc_rd;
  logic             wr_lo, wr_hi, wr_ctrl, wr_status, wr_srst;
  logic             flush;
  logic [2:0]       ctrl;
  logic [31:0]      stage_lo, stage_hi, lo_next, hi_next;
  logic [31:0]      wd_eff;
  logic [3:0]       be_eff;
  logic             soft_pulse;
  logic             overflow;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic             ovf_set;
  cap_state_e       state;
  logic [CW-1:0]    beat_cnt;
  logic [HASH_SIZE-1:0] hash;
  logic [511:0]     hash_ext;
  logic [63:0]      beat;
  logic             hash_ready;
  logic             status_clr;
  logic [31:0]      status;
  logic [31:0]      rdata_next;

  assign acc_wr    = chipselect & write;
  assign acc_rd    = chipselect & read;
  assign wr_lo     = acc_wr && (address == ADDR_DATA_LO);
  assign wr_hi     = acc_wr && (address == ADDR_DATA_HI);
  assign wr_ctrl   = acc_wr && (address == ADDR_CTRL);
  assign wr_status = acc_wr && (address == ADDR_STATUS);
  assign wr_srst   = acc_wr && (address == ADDR_SOFT_RST);
  assign flush     = reset | wr_srst;

  assign core_rst       = reset | soft_pulse;
  assign core_dst_ready = reset | soft_pulse;
  assign core_src_ready = reset | fifo_empty;

  assign wd_eff = ctrl[CTRL_SWAP_IN] ? bswap32(writedata) : writedata;
  assign be_eff = ctrl[CTRL_SWAP_IN] ? rev4(byteenable) : byteenable;

  always_comb begin
    lo_next = stage_lo;
    hi_next = stage_hi;
    for (int i = 0; i < 4; i++) begin
      if (be_eff[i]) begin
        if (wr_lo) lo_next[8*i +: 8] = wd_eff[8*i +: 8];
        if (wr_hi) hi_next[8*i +: 8] = wd_eff[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= writedata[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      stage_lo <= '0;
      stage_hi <= '0;
    end else begin
      stage_lo <= lo_next;
      stage_hi <= hi_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) soft_pulse <= 1'b0;
    else       soft_pulse <= wr_srst;
  end

  // The merged high word goes straight into the FIFO on the edge that takes DATA_HI.
  hash_word_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (flush),
    .push      (wr_hi),
    .push_data ({hi_next, stage_lo}),
    .pop       (core_src_read),
    .head      (core_din),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign ovf_set = wr_hi & fifo_full & ~core_src_read;

  always_ff @(posedge clk) begin
    if (flush) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (wr_status && writedata[ST_OVERFLOW]) begin
      overflow <= 1'b0;
    end
  end

  assign beat       = ctrl[CTRL_SWAP_OUT] ? bswap64(core_dout) : core_dout;
  assign hash_ready = (state == CAP_DONE);
  assign status_clr = (wr_status && writedata[ST_HASH_READY]) || wr_hi;

  always_ff @(posedge clk) begin
    if (flush) begin
      state    <= CAP_IDLE;
      beat_cnt <= '0;
      hash     <= '0;
    end else begin
      // Beat 0 ends up in the lowest 64 bits once all beats have been shifted in.
      if (core_dst_write) hash <= {beat, hash[HASH_SIZE-1:64]};
      case (state)
        CAP_IDLE: begin
          if (core_dst_write) begin
            state    <= CAP_COLLECT;
            beat_cnt <= CW'(1);
          end
        end
        CAP_COLLECT: begin
          if (core_dst_write) begin
            if (beat_cnt == CW'(BEATS - 1)) begin
              state    <= CAP_DONE;
              beat_cnt <= CW'(BEATS);
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        CAP_DONE: begin
          if (core_dst_write) begin
            state    <= CAP_COLLECT;
            beat_cnt <= CW'(1);
          end else if (status_clr) begin
            state    <= CAP_IDLE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= CAP_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= hash_ready & ctrl[CTRL_IRQ_EN];
  end

  always_comb begin
    status                = '0;
    status[ST_HASH_READY] = hash_ready;
    status[ST_FIFO_FULL]  = fifo_full;
    status[ST_FIFO_EMPTY] = fifo_empty;
    status[ST_OVERFLOW]   = overflow;
    status[ST_BUSY]       = (state == CAP_COLLECT);
    status[14:8]          = 7'(fifo_level);
  end

  // Zero-extending the digest makes the upper HASH words read 0 for 256-bit digests.
  assign hash_ext = 512'(hash);

  always_comb begin
    rdata_next = '0;
    case (address)
      ADDR_CTRL:   rdata_next = {29'd0, ctrl};
      ADDR_STATUS: rdata_next = status;
      default: begin
        if (address[5:4] == 2'b10) rdata_next = hash_ext[{address[3:0], 5'd0} +: 32];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (acc_rd) begin
      readdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_hash_avalon_bridge.sv
// tb/tb_hash_avalon_bridge.sv - randomized self-checking bench against a queue-based reference model
module tb_hash_avalon_bridge;

  localparam int HASH_SIZE  = 512;
  localparam int FIFO_DEPTH = 8;
  localparam int BEATS      = HASH_SIZE / 64;
  localparam logic [5:0] A_LO = 6'h00, A_HI = 6'h01, A_CTRL = 6'h02, A_STAT = 6'h03;
  localparam logic [5:0] A_SRST = 6'h0F, A_HASH = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write, read, chipselect;
  logic [31:0] readdata;
  logic        irq, core_rst, core_src_ready, core_src_read, core_dst_ready, core_dst_write;
  logic [63:0] core_din, core_dout;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_q[$];
  bit          model_ovf;
  logic [31:0] m_lo, m_hi;
  logic [2:0]  m_ctrl;

  always #5 clk = ~clk;

  hash_avalon_bridge #(.HASH_SIZE(HASH_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .writedata(writedata),
    .byteenable(byteenable), .write(write), .read(read), .chipselect(chipselect),
    .readdata(readdata), .irq(irq), .core_rst(core_rst), .core_src_ready(core_src_ready),
    .core_src_read(core_src_read), .core_din(core_din), .core_dst_ready(core_dst_ready),
    .core_dst_write(core_dst_write), .core_dout(core_dout)
  );

  function automatic logic [63:0] rev_bytes(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*(n-1-i) +: 8] = v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_status(input bit hr, input bit busy);
    logic [31:0] s;
    int n;
    n = model_q.size();
    s = '0;
    s[0] = hr;
    s[1] = (n == FIFO_DEPTH);
    s[2] = (n == 0);
    s[3] = model_ovf;
    s[4] = busy;
    s[14:8] = 7'(n);
    return s;
  endfunction

  function automatic void model_clear();
    model_q.delete();
    model_ovf = 0;
    m_lo = '0;
    m_hi = '0;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1; chipselect = 1'b1;
    @(negedge clk);
    write = 1'b0; chipselect = 1'b0;
    if (a == A_CTRL) m_ctrl = d[2:0];
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    address = a; read = 1'b1; chipselect = 1'b1;
    @(negedge clk);
    read = 1'b0; chipselect = 1'b0;
    d = readdata;
  endtask

  function automatic void model_stage(input bit hi, input logic [31:0] d, input logic [3:0] be);
    int p;
    for (int j = 0; j < 4; j++) begin
      if (be[j]) begin
        p = m_ctrl[0] ? 3 - j : j;
        if (hi) m_hi[8*p +: 8] = d[8*j +: 8];
        else    m_lo[8*p +: 8] = d[8*j +: 8];
      end
    end
  endfunction

  task automatic stage_write(input bit hi, input logic [31:0] d, input logic [3:0] be);
    bus_write(hi ? A_HI : A_LO, d, be);
    model_stage(hi, d, be);
    if (hi) begin
      if (model_q.size() == FIFO_DEPTH) model_ovf = 1;
      else model_q.push_back({m_hi, m_lo});
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    stage_write(0, w[31:0], 4'hF);
    stage_write(1, w[63:32], 4'hF);
  endtask

  task automatic check_status(input string name, input bit hr, input bit busy);
    logic [31:0] got, exp;
    exp = exp_status(hr, busy);
    bus_read(A_STAT, got);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s status: got %08h want %08h", name, got, exp);
    end
  endtask

  task automatic pop_word(input string name);
    total++;
    if (core_src_ready !== (model_q.size() == 0)) begin
      bad++;
      $display("FAIL %s src_ready: got %0b want %0b", name, core_src_ready, model_q.size() == 0);
    end
    if (model_q.size() != 0) begin
      total++;
      if (core_din !== model_q[0]) begin
        bad++;
        $display("FAIL %s din: got %016h want %016h", name, core_din, model_q[0]);
      end
    end
    core_src_read = 1'b1;
    @(negedge clk);
    core_src_read = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic drain(input string name);
    while (model_q.size() != 0) pop_word(name);
    total++;
    if (core_src_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s drained src_ready: got %0b want 1", name, core_src_ready);
    end
  endtask

  task automatic send_beat(input logic [63:0] b);
    core_dout = b; core_dst_write = 1'b1;
    @(negedge clk);
    core_dst_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({core_rst, core_src_ready, core_dst_ready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_outs: got %03b want 111", {core_rst, core_src_ready, core_dst_ready});
    end
    reset = 1'b0;
    m_ctrl = '0;
    model_clear();
    @(negedge clk);
    total++;
    if ({core_rst, core_dst_ready, core_src_ready, irq} !== 4'b0010 || readdata !== 32'd0) begin
      bad++;
      $display("FAIL post_reset: got rst/dst/src/irq=%04b rd=%08h want 0010 rd=0",
               {core_rst, core_dst_ready, core_src_ready, irq}, readdata);
    end
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %08h want 0", d); end
    check_status("reset", 0, 0);
    bus_read(A_HASH, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_hash0: got %08h want 0", d); end
  endtask

  task automatic test_push_basic();
    bus_write(A_CTRL, 32'd0, 4'hF);
    stage_write(0, 32'h03020100, 4'hF);
    stage_write(1, 32'h07060504, 4'hF);
    total++;
    if (core_src_ready !== 1'b0 || core_din !== 64'h0706050403020100) begin
      bad++;
      $display("FAIL push_basic: got ready=%0b din=%016h want 0 0706050403020100", core_src_ready, core_din);
    end
    check_status("push_basic", 0, 0);
    drain("push_basic");
  endtask

  task automatic test_byte_lanes();
    stage_write(0, 32'hAAAAAAAA, 4'hF);
    stage_write(0, 32'h12345678, 4'b0101);
    stage_write(1, $urandom, 4'hF);
    stage_write(1, $urandom, 4'b1010);
    drain("byte_lanes");
    bus_write(A_CTRL, 32'h1, 4'hF);
    stage_write(0, 32'h11223344, 4'hF);
    stage_write(1, 32'h55667788, 4'hF);
    total++;
    if (core_din !== 64'h8877665544332211) begin
      bad++;
      $display("FAIL swap_in: got %016h want 8877665544332211", core_din);
    end
    stage_write(0, $urandom, 4'b0011);
    stage_write(1, $urandom, 4'b1100);
    drain("swap_in");
    bus_write(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) push_word({$urandom, $urandom});
    check_status("overflow", 0, 0);
    bus_write(A_STAT, 32'h8, 4'hF);
    model_ovf = 0;
    check_status("overflow_w1c", 0, 0);
    drain("overflow");
  endtask

  task automatic test_full_simul();
    logic [63:0] w;
    for (int i = 0; i < FIFO_DEPTH; i++) push_word({$urandom, $urandom});
    w = {$urandom, $urandom};
    stage_write(0, w[31:0], 4'hF);
    model_stage(1, w[63:32], 4'hF);
    address = A_HI; writedata = w[63:32]; byteenable = 4'hF; write = 1'b1; chipselect = 1'b1;
    core_src_read = 1'b1;
    total++;
    if (core_din !== model_q[0]) begin
      bad++;
      $display("FAIL full_simul head: got %016h want %016h", core_din, model_q[0]);
    end
    @(negedge clk);
    write = 1'b0; chipselect = 1'b0; core_src_read = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back({m_hi, m_lo});
    check_status("full_simul", 0, 0);
    drain("full_simul");
  endtask

  task automatic test_capture(input bit swap_out, input bit irq_en);
    logic [63:0]  b[BEATS];
    logic [511:0] exp_hash;
    logic [31:0]  d;
    bus_write(A_CTRL, {29'd0, irq_en, swap_out, 1'b0}, 4'hF);
    push_word({$urandom, $urandom});
    exp_hash = '0;
    for (int i = 0; i < BEATS; i++) begin
      b[i] = {$urandom, 24'(i), 8'(i)};
      exp_hash[64*i +: 64] = swap_out ? rev_bytes(b[i], 8) : b[i];
      send_beat(b[i]);
      if (i == 2) check_status("capture_busy", 0, 1);
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %0b want 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== irq_en) begin bad++; $display("FAIL irq_late: got %0b want %0b", irq, irq_en); end
    check_status("capture_done", 1, 0);
    for (int k = 0; k < 16; k++) begin
      bus_read(A_HASH + 6'(k), d);
      total++;
      if (d !== exp_hash[32*k +: 32]) begin
        bad++;
        $display("FAIL hash_word%0d: got %08h want %08h", k, d, exp_hash[32*k +: 32]);
      end
    end
    bus_write(A_STAT, 32'h1, 4'hF);
    check_status("capture_clear", 0, 0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %0b want 0", irq); end
    drain("capture");
  endtask

  task automatic test_soft_rst();
    logic [31:0] d;
    bus_write(A_CTRL, 32'h5, 4'hF);
    push_word({$urandom, $urandom});
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom});
    address = A_SRST; writedata = $urandom; byteenable = 4'hF; write = 1'b1; chipselect = 1'b1;
    @(negedge clk);
    write = 1'b0; chipselect = 1'b0;
    model_clear();
    total++;
    if (core_rst !== 1'b1 || core_dst_ready !== 1'b1) begin
      bad++;
      $display("FAIL soft_rst_pulse: got rst=%0b dst=%0b want 1 1", core_rst, core_dst_ready);
    end
    @(negedge clk);
    total++;
    if (core_rst !== 1'b0 || core_dst_ready !== 1'b0) begin
      bad++;
      $display("FAIL soft_rst_end: got rst=%0b dst=%0b want 0 0", core_rst, core_dst_ready);
    end
    check_status("soft_rst", 0, 0);
    for (int k = 0; k < 16; k++) begin
      bus_read(A_HASH + 6'(k), d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL soft_hash%0d: got %08h want 0", k, d); end
    end
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL soft_ctrl: got %08h want 5", d); end
    bus_write(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_read_hold();
    logic [31:0] d, held;
    held = exp_status(0, 0);
    bus_read(A_STAT, d);
    total++;
    if (d !== held) begin bad++; $display("FAIL read_t1: got %08h want %08h", d, held); end
    push_word({$urandom, $urandom});
    @(negedge clk);
    total++;
    if (readdata !== held) begin bad++; $display("FAIL read_hold: got %08h want %08h", readdata, held); end
    check_status("read_new", 0, 0);
    bus_write(6'h3A, $urandom, 4'hF);
    bus_read(6'h3A, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL unmapped: got %08h want 0", d); end
    drain("read_hold");
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) push_word({$urandom, $urandom});
      else pop_word("random");
    end
    check_status("random", 0, 0);
    drain("random");
  endtask

  task automatic test_reset_mid_capture();
    push_word({$urandom, $urandom});
    stage_write(0, $urandom, 4'hF);
    send_beat({$urandom, $urandom});
    send_beat({$urandom, $urandom});
    test_reset();
    test_capture(0, 0);
  endtask

  initial begin
    reset = 1'b1; address = '0; writedata = '0; byteenable = '0;
    write = 1'b0; read = 1'b0; chipselect = 1'b0;
    core_src_read = 1'b0; core_dst_write = 1'b0; core_dout = '0;
    m_ctrl = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_push_basic();
    test_byte_lanes();
    test_overflow();
    test_full_simul();
    test_capture(0, 1);
    test_capture(1, 0);
    test_soft_rst();
    test_read_hold();
    test_random_traffic();
    test_reset_mid_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
